// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared constants, state encoding and helpers for the DA FIR coefficient path
package da_pkg;

    localparam int COEF_W    = 16;
    localparam int LUT_W     = COEF_W + 2;
    localparam int TAPS      = 4;
    localparam int ROM_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int IDX_W     = 2;

    // Loader state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_GEN     = 3'd2;
    localparam logic [2:0] ST_WAIT_GO = 3'd3;
    localparam logic [2:0] ST_START   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Active-low ROM strobe levels shared with the filter control
    localparam logic ROM_CEN_ACTIVE = 1'b0;
    localparam logic ROM_WEN_ACTIVE = 1'b0;

    typedef logic [TAPS-1:0][COEF_W-1:0] coef_bank_t;

    // Widen one coefficient to ROM word width, preserving sign
    function automatic logic signed [LUT_W-1:0] sext_coef(input logic [COEF_W-1:0] c);
        return {{(LUT_W-COEF_W){c[COEF_W-1]}}, c};
    endfunction

endpackage

// File: rtl/da_rom_loader_if.sv
// rtl/da_rom_loader_if.sv - coefficient stream in, ROM write port and start/done out
interface da_rom_loader_if;
    import da_pkg::*;

    logic [COEF_W-1:0] coef_data;
    logic              coef_valid;
    logic              coef_ready;
    logic              go;
    logic              cload;
    logic              rom_valid;
    logic [ADDR_W-1:0] rom_addr;
    logic [LUT_W-1:0]  rom_data;
    logic              start;
    logic              done;

    // Upstream side: supplies coefficients and the start request
    modport master (
        output coef_data, coef_valid, go,
        input  coef_ready, cload, rom_valid, rom_addr, rom_data, start, done
    );

    // Loader side
    modport slave (
        input  coef_data, coef_valid, go,
        output coef_ready, cload, rom_valid, rom_addr, rom_data, start, done
    );
endinterface

// File: rtl/da_lut_adder.sv
// rtl/da_lut_adder.sv - combinational subset sum of four coefficients selected by a ROM address
module da_lut_adder
    import da_pkg::*;
(
    input  coef_bank_t              coefs,
    input  logic [ADDR_W-1:0]       addr,
    output logic signed [LUT_W-1:0] sum
);

    // Add every tap whose address bit is set; two guard bits absorb the 4-term growth
    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (addr[i]) begin
                sum = sum + sext_coef(coefs[i]);
            end
        end
    end

endmodule

// File: rtl/da_rom_loader.sv
// rtl/da_rom_loader.sv - builds the 16-word DA ROM image from 4 taps, then starts the filter (option: DA_LOADER_AUTOSTART_EN)
module da_rom_loader
    import da_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    da_rom_loader_if.slave bus
);

    logic [2:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W-1:0]       lut_addr;
    coef_bank_t              coef_q, coef_d;
    logic signed [LUT_W-1:0] lut_sum;
    logic signed [LUT_W-1:0] data_q, data_d;
    logic                    ready_q, ready_d;
    logic                    gen_q, gen_d;
    logic                    start_q, start_d;
    logic                    done_q, done_d;

    da_lut_adder u_lut_adder (
        .coefs (coef_d),
        .addr  (lut_addr),
        .sum   (lut_sum)
    );

    // Next-state and next-output decode; every output is a flop so the filter sees clean levels at negedge
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        coef_d   = coef_q;
        data_d   = data_q;
        ready_d  = 1'b0;
        gen_d    = 1'b0;
        start_d  = 1'b0;
        done_d   = 1'b0;
        lut_addr = addr_q + ADDR_W'(1);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_COLLECT;
                ready_d = 1'b1;
            end
            ST_COLLECT: begin
                ready_d = 1'b1;
                if (bus.coef_valid && ready_q) begin
                    coef_d[idx_q] = bus.coef_data;
                    idx_d         = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(TAPS - 1)) begin
                        // Word 0 goes out on the very next cycle; it never depends on the tap just stored
                        state_d  = ST_GEN;
                        ready_d  = 1'b0;
                        gen_d    = 1'b1;
                        addr_d   = '0;
                        lut_addr = '0;
                        data_d   = lut_sum;
                    end
                end
            end
            ST_GEN: begin
                if (addr_q == ADDR_W'(ROM_DEPTH - 1)) begin
`ifdef DA_LOADER_AUTOSTART_EN
                    state_d = ST_START;
                    start_d = 1'b1;
`else
                    state_d = ST_WAIT_GO;
`endif
                end else begin
                    gen_d  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    data_d = lut_sum;
                end
            end
`ifndef DA_LOADER_AUTOSTART_EN
            ST_WAIT_GO: begin
                if (bus.go) begin
                    state_d = ST_START;
                    start_d = 1'b1;
                end
            end
`endif
            ST_START: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                // Terminal until reset: the filter ROM is only rewritten after reset
                done_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, coefficient and output registers; reset abandons any partial ROM image
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            coef_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            gen_q   <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            coef_q  <= coef_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            gen_q   <= gen_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign bus.coef_ready = ready_q;
    assign bus.cload      = gen_q;
    assign bus.rom_valid  = gen_q;
    assign bus.rom_addr   = addr_q;
    assign bus.rom_data   = data_q;
    assign bus.start      = start_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_da_rom_loader.sv
// tb/tb_da_rom_loader.sv - scoreboard bench for da_rom_loader (honours DA_LOADER_AUTOSTART_EN)
module tb_da_rom_loader;
    import da_pkg::*;

    typedef struct {
        int addr;
        int data;
    } word_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    da_rom_loader_if bus ();

    da_rom_loader dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int    tests = 0;
    int    fails = 0;
    word_t exp_q[$];
    int    seen[16];
    int    start_count = 0;
    bit    prev_valid = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lut_model(input int c[4], input int a);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            if (((a >> i) & 1) == 1) s += c[i];
        end
        return s;
    endfunction

    // Monitor: pops the expected ROM word whenever the DUT presents one
    always @(negedge clk) begin
        word_t w;
        int    act;
        if (resetn) begin
            if (bus.rom_valid) begin
                act = int'($signed(bus.rom_data));
                check(bus.cload == 1'b1, "cload_with_valid", int'(bus.cload), 1);
                check(exp_q.size() > 0, "unexpected_word", int'(bus.rom_addr), -1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check(int'(bus.rom_addr) == w.addr, "rom_addr", int'(bus.rom_addr), w.addr);
                    check(act == w.data, "rom_data", act, w.data);
                end
                if (bus.rom_addr != 4'd0) check(prev_valid, "no_bubble", int'(prev_valid), 1);
                seen[bus.rom_addr] = act;
            end
            if (bus.start) start_count++;
        end
        prev_valid = bus.rom_valid;
    end

    task automatic check_zero(input string tag);
        check(bus.coef_ready == 1'b0, {tag, "_coef_ready"}, int'(bus.coef_ready), 0);
        check(bus.cload == 1'b0, {tag, "_cload"}, int'(bus.cload), 0);
        check(bus.rom_valid == 1'b0, {tag, "_rom_valid"}, int'(bus.rom_valid), 0);
        check(bus.rom_addr == '0, {tag, "_rom_addr"}, int'(bus.rom_addr), 0);
        check(bus.rom_data == '0, {tag, "_rom_data"}, int'(bus.rom_data), 0);
        check(bus.start == 1'b0, {tag, "_start"}, int'(bus.start), 0);
        check(bus.done == 1'b0, {tag, "_done"}, int'(bus.done), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_zero("reset");
        for (int k = 0; k < 16; k++) seen[k] = -999999;
        start_count = 0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic push_image(input int c[4]);
        for (int k = 0; k < 16; k++) exp_q.push_back('{addr: k, data: lut_model(c, k)});
    endtask

    task automatic send_coefs(input int c[4], input int gap);
        int n;
        for (int i = 0; i < 4; i++) begin
            bus.coef_data  = 16'(c[i]);
            bus.coef_valid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.coef_ready && n < 50);
            check(bus.coef_ready == 1'b1, "coef_ready_wait", int'(bus.coef_ready), 1);
            @(posedge clk);
            #1;
            if (i == 3) push_image(c);
            bus.coef_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_words();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check(exp_q.size() == 0, "all_words_seen", exp_q.size(), 0);
    endtask

    task automatic finish_start();
`ifdef DA_LOADER_AUTOSTART_EN
        @(negedge clk);
        check(bus.start == 1'b1, "auto_start", int'(bus.start), 1);
        check(bus.cload == 1'b0, "cload_at_start", int'(bus.cload), 0);
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check(bus.cload == 1'b0, "wait_go_cload", int'(bus.cload), 0);
            check(bus.start == 1'b0, "wait_go_start", int'(bus.start), 0);
        end
        bus.go = 1'b1;
        @(negedge clk);
        check(bus.start == 1'b1, "go_start", int'(bus.start), 1);
        bus.go = 1'b0;
`endif
        @(negedge clk);
        check(bus.start == 1'b0, "start_one_cycle", int'(bus.start), 0);
        check(bus.done == 1'b1, "done_after_start", int'(bus.done), 1);
        check(start_count == 1, "start_count", start_count, 1);
    endtask

    initial begin
        int c[4];
        int n;
        bus.coef_data  = '0;
        bus.coef_valid = 1'b0;
        bus.go         = 1'b0;

        // Identity image
        do_reset();
        c = '{1, 2, 4, 8};
        send_coefs(c, 0);
        wait_words();
        finish_start();
        for (int k = 0; k < 16; k++) check(seen[k] == k, "identity_word", seen[k], k);

        // Most-negative coefficients
        do_reset();
        c = '{-32768, -32768, -32768, -32768};
        send_coefs(c, 0);
        wait_words();
        finish_start();
        check(seen[15] == -131072, "neg_addr15", seen[15], -131072);
        check(seen[1] == -32768, "neg_addr1", seen[1], -32768);
        check(seen[0] == 0, "neg_addr0", seen[0], 0);

        // Mixed signs with gaps in coef_valid
        do_reset();
        c = '{3, -5, 7, -1};
        send_coefs(c, 2);
        wait_words();
        finish_start();
        check(seen[6] == 2, "mixed_addr6", seen[6], 2);
        check(seen[15] == 4, "mixed_addr15", seen[15], 4);

        // Extra beats after done are ignored
        bus.coef_data  = 16'h1234;
        bus.coef_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(bus.coef_ready == 1'b0, "done_coef_ready", int'(bus.coef_ready), 0);
            check(bus.rom_valid == 1'b0, "done_rom_valid", int'(bus.rom_valid), 0);
            check(bus.start == 1'b0, "done_start", int'(bus.start), 0);
            check(bus.done == 1'b1, "done_sticky", int'(bus.done), 1);
        end
        bus.coef_valid = 1'b0;
        check(start_count == 1, "done_no_restart", start_count, 1);

        // Reset in the middle of GEN, then a clean reload
        do_reset();
        c = '{1, 2, 4, 8};
        send_coefs(c, 0);
        n = 0;
        while (!(bus.rom_valid && bus.rom_addr == 4'd7) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(bus.rom_addr == 4'd7, "reach_addr7", int'(bus.rom_addr), 7);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check_zero("async_reset");
        for (int k = 0; k < 16; k++) seen[k] = -999999;
        @(negedge clk);
        start_count = 0;
        resetn = 1'b1;
        c = '{1, 1, 1, 1};
        send_coefs(c, 0);
        wait_words();
        finish_start();
        check(seen[0] == 0, "reload_addr0", seen[0], 0);
        check(seen[15] == 4, "reload_addr15", seen[15], 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
